apple2_lc_ram: RTL

Parametrised Apple II system RAM with an integrated 16 KB language card. It provides synchronous main RAM from $0000 up to MAIN_KB KB, banked RAM over $D000–$FFFF, and the $C080–$C08F soft-switch state machine, including the double-read write-enable qualifier. It sits between the 6502 bus and the ROM/IO mux. It drives `ram_hit` so the mux selects this block's `dout` or the ROM/IO data.

---
 rtl/apple2_lc_ram.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/apple2_lc_ram.sv
// apple2_lc_ram
//
// Apple II system RAM with a 16 KB language card.
//
// Holds main RAM from $0000 up to MAIN_KB KB, the banked language-card RAM
// over $D000-$FFFF, and the $C080-$C08F soft-switch logic that controls the
// card. Reads are synchronous with one cycle of latency. ram_hit tells the
// downstream ROM/IO mux whether dout carries RAM data for the previous
// cycle's address.
//
// Parameters:
//   MAIN_KB     main RAM size in KB (1..48), mapped from $0000
//   LC_EN       1 = language card present, 0 = card absent
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   address     CPU address
//   access      one-cycle strobe marking a CPU bus cycle
//   w_en        1 = write cycle (only meaningful with access)
//   din         write data
//   dout        registered read data, 8'h00 when ram_hit = 0
//   ram_hit     registered, 1 = dout is RAM data
//   lc_read_en  1 = $D000-$FFFF reads come from LC RAM
//   lc_write_en 1 = $D000-$FFFF writes go to LC RAM
//   lc_bank2    1 = $D000-$DFFF uses bank 2, 0 = bank 1
//
// Write-enable state machine (tracks lc_write_en together with the hidden
// prewrite flag that implements the double-read qualifier):
//   state    | meaning
//   WP_OFF   | writes disabled, prewrite clear
//   WP_ARMED | writes disabled, one odd read seen (prewrite set)
//   WP_ON    | writes enabled, prewrite set
//   WP_HELD  | writes enabled, prewrite cleared by an odd write cycle

module apple2_lc_ram #(
    parameter int MAIN_KB = 48,
    parameter bit LC_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        access,
    input  logic        w_en,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        ram_hit,
    output logic        lc_read_en,
    output logic        lc_write_en,
    output logic        lc_bank2
);

    localparam int MAIN_BYTES = MAIN_KB * 1024;
    localparam int MAIN_AW    = $clog2(MAIN_BYTES);

    typedef enum logic [1:0] {
        WP_OFF   = 2'd0,
        WP_ARMED = 2'd1,
        WP_ON    = 2'd2,
        WP_HELD  = 2'd3
    } wp_state_t;

    // Both arrays power up cleared; reset deliberately leaves them alone.
    logic [7:0] main_mem [0:MAIN_BYTES-1] = '{default: 8'h00};
    logic [7:0] lc_mem   [0:16383]        = '{default: 8'h00};

    wp_state_t    wp_state, wp_next;
    logic         read_en_next;
    logic         bank2_next;

    logic               main_sel;
    logic               lc_space;
    logic               lc_read_hit;
    logic               sw_access;
    logic [MAIN_AW-1:0] main_idx;
    logic [13:0]        lc_idx;

    assign main_sel    = ({1'b0, address} < 17'(MAIN_BYTES));
    assign main_idx    = address[MAIN_AW-1:0];
    assign lc_space    = LC_EN && (address >= 16'hD000);
    assign lc_read_hit = lc_space && lc_read_en;
    assign sw_access   = LC_EN && access && (address[15:4] == 12'hC08);

    // Subtracting $C000 from $D000-$FFFF just drops the top two bits.
    // Bank 1 of $D000-$DFFF instead folds down to offsets $0000-$0FFF.
    always_comb begin
        if ((address[15:12] == 4'hD) && !lc_bank2)
            lc_idx = {2'b00, address[11:0]};
        else
            lc_idx = address[13:0];
    end

    assign lc_write_en = (wp_state == WP_ON) || (wp_state == WP_HELD);

    // ---------------------------------------------------------------
    // Soft-switch state: register process
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_state   <= WP_OFF;
            lc_read_en <= 1'b0;
            lc_bank2   <= 1'b1;
        end else begin
            wp_state   <= wp_next;
            lc_read_en <= read_en_next;
            lc_bank2   <= bank2_next;
        end
    end

    // ---------------------------------------------------------------
    // Soft-switch state: next-state process
    // ---------------------------------------------------------------
    always_comb begin
        wp_next      = wp_state;
        read_en_next = lc_read_en;
        bank2_next   = lc_bank2;
        if (sw_access) begin
            bank2_next   = ~address[3];
            read_en_next = (address[0] == address[1]);
            if (!address[0]) begin
                wp_next = WP_OFF;
            end else if (!w_en) begin
                // Odd read: a second one (prewrite already set) enables writes.
                case (wp_state)
                    WP_OFF:  wp_next = WP_ARMED;
                    default: wp_next = WP_ON;
                endcase
            end else begin
                // Odd write: clears prewrite, write enable keeps its value.
                case (wp_state)
                    WP_ON, WP_HELD: wp_next = WP_HELD;
                    default:        wp_next = WP_OFF;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Array writes. Not gated by reset: a write coinciding with reset
    // still lands.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (access && w_en && main_sel)
            main_mem[main_idx] <= din;
        if (access && w_en && lc_write_en && lc_space)
            lc_mem[lc_idx] <= din;
    end

    // ---------------------------------------------------------------
    // Registered read path, every cycle. Sees array contents and LC
    // state from before this edge, so same-cycle writes read old data.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= 8'h00;
            ram_hit <= 1'b0;
        end else begin
            ram_hit <= main_sel || lc_read_hit;
            if (main_sel)
                dout <= main_mem[main_idx];
            else if (lc_read_hit)
                dout <= lc_mem[lc_idx];
            else
                dout <= 8'h00;
        end
    end

endmodule
